// File: rtl/audio_ram_pkg.sv
// Shared types and defaults for the audio RAM arbiter.
package audio_ram_pkg;

   localparam int unsigned AddrWDefault     = 26;
   localparam int unsigned DataWDefault     = 8;
   localparam int unsigned RdTimeoutDefault = 255;
   localparam int unsigned TimerW           = 8;

   typedef enum logic [1:0] {
      StIdle,
      StWr,
      StRdWait,
      StRdDone
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant bit 0 is record, bit 1 is playback.
module rr_arb2 (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   // last_q = 1 means playback was granted last, so record wins the next tie.
   logic last_q, last_d;

   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
         endcase
      end
   end

   always_comb begin
      last_d = last_q;
      if (gnt_o != 2'b00) begin
         last_d = gnt_o[1];
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/audio_ram_arbiter.sv
// Arbitrates record writes and playback reads onto a single RAM wrapper port.
module audio_ram_arbiter
   import audio_ram_pkg::*;
#(
   parameter int unsigned ADDR_W     = AddrWDefault,
   parameter int unsigned DATA_W     = DataWDefault,
   parameter int unsigned RD_TIMEOUT = RdTimeoutDefault
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              rec_req_i,
   input  logic [ADDR_W-1:0] rec_addr_i,
   input  logic [DATA_W-1:0] rec_data_i,
   output logic              rec_ack_o,
   input  logic              play_req_i,
   input  logic [ADDR_W-1:0] play_addr_i,
   output logic [DATA_W-1:0] play_data_o,
   output logic              play_valid_o,
   output logic              timeout_err_o,
   input  logic              ram_rdy_i,
   output logic [ADDR_W-1:0] ram_address_o,
   output logic [DATA_W-1:0] ram_data_in_o,
   output logic              ram_write_enable_o,
   output logic              ram_read_request_o,
   output logic              ram_read_ack_o,
   input  logic [DATA_W-1:0] ram_data_out_i,
   input  logic              ram_rd_data_pres_i
);

   state_e              state_q;
   logic [TimerW-1:0]   timer_q;
   logic [1:0]          gnt;
   logic [ADDR_W-1:0]   ram_address_q;
   logic [DATA_W-1:0]   ram_data_in_q;
   logic [DATA_W-1:0]   play_data_q;
   logic                rec_ack_q, play_valid_q, timeout_err_q;
   logic                ram_we_q, ram_rreq_q, ram_rack_q;

   rr_arb2 u_rr_arb2 (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    ((state_q == StIdle) && ram_rdy_i),
      .req_i   ({play_req_i, rec_req_i}),
      .gnt_o   (gnt)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= StIdle;
         timer_q       <= '0;
         ram_address_q <= '0;
         ram_data_in_q <= '0;
         play_data_q   <= '0;
         rec_ack_q     <= 1'b0;
         play_valid_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         ram_we_q      <= 1'b0;
         ram_rreq_q    <= 1'b0;
         ram_rack_q    <= 1'b0;
      end else begin
         // Every strobe defaults low so each is exactly one cycle wide.
         rec_ack_q     <= 1'b0;
         play_valid_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         ram_we_q      <= 1'b0;
         ram_rreq_q    <= 1'b0;
         ram_rack_q    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (gnt[0]) begin
                  ram_address_q <= rec_addr_i;
                  ram_data_in_q <= rec_data_i;
                  ram_we_q      <= 1'b1;
                  rec_ack_q     <= 1'b1;
                  state_q       <= StWr;
               end else if (gnt[1]) begin
                  ram_address_q <= play_addr_i;
                  ram_rreq_q    <= 1'b1;
                  timer_q       <= '0;
                  state_q       <= StRdWait;
               end
            end
            StWr: state_q <= StIdle;
            StRdWait: begin
               // Data presence takes priority over an expiring timer.
               if (ram_rd_data_pres_i) begin
                  play_data_q  <= ram_data_out_i;
                  play_valid_q <= 1'b1;
                  ram_rack_q   <= 1'b1;
                  state_q      <= StRdDone;
               end else if (timer_q == TimerW'(RD_TIMEOUT - 1)) begin
                  timeout_err_q <= 1'b1;
                  state_q       <= StIdle;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            StRdDone: state_q <= StIdle;
            default:  state_q <= StIdle;
         endcase
      end
   end

   assign rec_ack_o          = rec_ack_q;
   assign play_data_o        = play_data_q;
   assign play_valid_o       = play_valid_q;
   assign timeout_err_o      = timeout_err_q;
   assign ram_address_o      = ram_address_q;
   assign ram_data_in_o      = ram_data_in_q;
   assign ram_write_enable_o = ram_we_q;
   assign ram_read_request_o = ram_rreq_q;
   assign ram_read_ack_o     = ram_rack_q;

endmodule
